// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Holds the response-state encoding and the default starvation limit.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } rsp_state_e;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int SRAM_DW          = 32;
    localparam int SRAM_BEW         = SRAM_DW / 8;

    function automatic logic is_read(input logic [SRAM_BEW-1:0] we);
        return we == '0;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_starve_cnt.sv
// Fetch starvation counter: counts consecutive denied fetch cycles
// and flags when the limit is reached so fetch can win one cycle.
module arb_starve_cnt
    import sram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and data ports onto one SRAM, data first by default.
// Define ARB_STARVE_EN to let a starved fetch win one cycle at the limit.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [SRAM_DW-1:0]  if_rdata,
    input  logic                dm_req,
    input  logic [SRAM_BEW-1:0] dm_we,
    input  logic [31:0]         dm_addr,
    input  logic [SRAM_DW-1:0]  dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [SRAM_DW-1:0]  dm_rdata,
    output logic                sram_en,
    output logic [SRAM_BEW-1:0] sram_we,
    output logic [31:0]         sram_addr,
    output logic [SRAM_DW-1:0]  sram_wdata,
    input  logic [SRAM_DW-1:0]  sram_rdata,
    output logic                stall_req
);

    logic       if_win;
    logic       dm_win;
    logic       starve_hit;
    rsp_state_e state_q;

`ifdef ARB_STARVE_EN
    arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req     (if_req),
        .gnt     (if_gnt),
        .at_limit(starve_hit)
    );
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;
    assign starve_hit   = 1'b0;
`endif

    always_comb begin
        if_win = if_req & (~dm_req | starve_hit);
        dm_win = dm_req & ~if_win;
    end

    assign if_gnt    = if_win;
    assign dm_gnt    = dm_win;
    assign stall_req = (if_req & ~if_win) | (dm_req & ~dm_win);

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            if_win: begin
                sram_en   = 1'b1;
                sram_addr = if_addr;
            end
            dm_win: begin
                sram_en    = 1'b1;
                sram_we    = dm_we;
                sram_addr  = dm_addr;
                sram_wdata = dm_wdata;
            end
            default: ;
        endcase
    end

    // Records who owns the data the SRAM returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            unique case (1'b1)
                if_win:                   state_q <= RESP_IF;
                dm_win && is_read(dm_we): state_q <= RESP_DM;
                default:                  state_q <= IDLE;
            endcase
        end
    end

    // Reset gates rvalid so a response in flight at reset is dropped.
    assign if_rvalid = ~rst & (state_q == RESP_IF);
    assign dm_rvalid = ~rst & (state_q == RESP_DM);
    assign if_rdata  = if_rvalid ? sram_rdata : '0;
    assign dm_rdata  = dm_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_sram_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall_req;

    int n_vec = 0;
    int n_err = 0;
    int m_pend = 0;
    int m_cnt = 0;
    bit starve_en;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .stall_req (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                        input bit dr, input logic [3:0] we,
                        input logic [31:0] da, input logic [31:0] dw,
                        input logic [31:0] rd);
        bit e_if, e_dm, e_en, e_ifv, e_dmv, e_stall;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia; dm_req = dr;
        dm_we = we; dm_addr = da; dm_wdata = dw; sram_rdata = rd;
        #1;
        e_if = ir && (!dr || (starve_en && m_cnt == LIM));
        e_dm = dr && !e_if;
        e_en = e_if || e_dm;
        e_we = e_dm ? we : 4'd0;
        e_addr = e_if ? ia : da;
        e_wd = e_dm ? dw : 32'd0;
        e_ifv = !r && m_pend == 1;
        e_dmv = !r && m_pend == 2;
        e_stall = (ir && !e_if) || (dr && !e_dm);
        check("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
        check("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm});
        check("sram_en", {31'd0, sram_en}, {31'd0, e_en});
        check("sram_we", {28'd0, sram_we}, {28'd0, e_we});
        if (e_en) begin
            check("sram_addr", sram_addr, e_addr);
            check("sram_wdata", sram_wdata, e_wd);
        end
        check("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_ifv});
        check("if_rdata", if_rdata, e_ifv ? rd : 32'd0);
        check("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e_dmv});
        check("dm_rdata", dm_rdata, e_dmv ? rd : 32'd0);
        check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
        if (r) begin
            m_pend = 0;
            m_cnt = 0;
        end else begin
            m_pend = e_if ? 1 : (e_dm && we == 4'd0) ? 2 : 0;
            if (!ir || e_if) m_cnt = 0;
            else if (m_cnt < LIM) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle(input logic [31:0] rd);
        step(0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, rd);
    endtask

    initial begin
`ifdef ARB_STARVE_EN
        starve_en = 1'b1;
`else
        starve_en = 1'b0;
`endif
        step(1, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'h1111_1111);
        step(1, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'h2222_2222);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);

        step(0, 1, 32'h1000, 0, 4'd0, 32'd0, 32'd0, 32'd0);
        check("f_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("f_addr", sram_addr, 32'h1000);
        idle(32'hDEAD_BEEF);
        check("f_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("f_rdata", if_rdata, 32'hDEAD_BEEF);

        step(0, 1, 32'h40, 1, 4'd0, 32'h2004, 32'd0, 32'd0);
        check("pri_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("pri_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("pri_stall", {31'd0, stall_req}, 32'd1);
        idle(32'h1234_5678);
        check("pri_dm_rv", {31'd0, dm_rvalid}, 32'd1);
        check("pri_if_rv", {31'd0, if_rvalid}, 32'd0);

        step(0, 0, 32'd0, 1, 4'b0011, 32'h3000, 32'h0000_ABCD, 32'd0);
        check("wr_we", {28'd0, sram_we}, 32'h3);
        check("wr_wdata", sram_wdata, 32'h0000_ABCD);
        idle(32'h5555_AAAA);
        check("wr_no_dmrv", {31'd0, dm_rvalid}, 32'd0);
        check("wr_no_ifrv", {31'd0, if_rvalid}, 32'd0);

        step(0, 0, 32'd0, 1, 4'd0, 32'h2008, 32'd0, 32'd0);
        step(1, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 32'h7777_7777);
        check("rstp_dm_rv0", {31'd0, dm_rvalid}, 32'd0);
        idle(32'h8888_8888);
        check("rstp_dm_rv1", {31'd0, dm_rvalid}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(0, 1, 32'h100 + i, 0, 4'd0, 32'd0, 32'd0, 32'hA0 + i);
            else
                step(0, 0, 32'd0, 1, 4'd0, 32'h200 + i, 32'd0, 32'hA0 + i);
            if (i > 0) begin
                if (i % 2 == 1)
                    check("alt_if_rv", {31'd0, if_rvalid}, 32'd1);
                else
                    check("alt_dm_rv", {31'd0, dm_rvalid}, 32'd1);
            end
        end
        idle(32'hBEEF);
        check("alt_last_dm", {31'd0, dm_rvalid}, 32'd1);

`ifdef ARB_STARVE_EN
        idle(32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 32'h400, 1, 4'd0, 32'h500, 32'd0, 32'd0);
            check("stv_if_gnt", {31'd0, if_gnt}, (k == 5) ? 32'd1 : 32'd0);
        end
`endif

        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), $urandom(),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom()),
                 $urandom(), $urandom(), $urandom());
        end
        idle(32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied IF cycles before IF wins one cycle; legal range 1..15.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch issued this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetch data.
- dm_req  in  1  data request.
- dm_we  in  4  byte write enables; 0 means read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  data access issued this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  32  load data.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid one cycle after issue.
- stall_req  out  1  requests pipeline stall.

Function
REQ-003 SHALL issue at most one SRAM access per cycle; grant is combinational, in the same cycle as issue.
REQ-004 SHALL give dm priority over if by default.
- Exception: if wins when if_req=1 and starve_cnt==STARVE_LIMIT.
REQ-005 When no request is present, SHALL drive sram_en=0, sram_we=0, if_gnt=0 and dm_gnt=0.
REQ-006 On an if grant, SHALL drive sram_en=1, sram_we=0, sram_addr=if_addr and sram_wdata=0.
REQ-007 On a dm grant, SHALL drive sram_en=1, sram_we=dm_we, sram_addr=dm_addr and sram_wdata=dm_wdata.
REQ-008 SHALL use a response FSM with states IDLE, RESP_IF and RESP_DM.
- Next state is RESP_IF after an if grant.
- Next state is RESP_DM after a dm read grant (dm_we==0).
- Next state is IDLE otherwise, including after any dm write.
REQ-009 Response outputs SHALL depend on state.
- In RESP_IF: if_rvalid=1 and if_rdata=sram_rdata.
- In RESP_DM: dm_rvalid=1 and dm_rdata=sram_rdata.
- Otherwise: rvalid=0 and rdata=0.
REQ-010 A new grant SHALL be allowed in the same cycle a response is returned; back-to-back reads sustain one access per cycle.
REQ-011 starve_cnt (4 bits) SHALL follow these rules:
- Increments when if_req=1 and if_gnt=0.
- Saturates at STARVE_LIMIT.
- Clears to 0 on if_gnt=1 or if_req=0.
REQ-012 SHALL drive stall_req=(if_req & ~if_gnt) | (dm_req & ~dm_gnt).
REQ-013 When requests drop while a response is pending, the response SHALL still be delivered in the next cycle.

Reset
REQ-014 On rst=1 at a clk edge, SHALL set state to IDLE and starve_cnt to 0.
REQ-015 During reset, if_rvalid and dm_rvalid SHALL be 0.
- Grant outputs remain combinational on requests.
REQ-016 A response pending when rst is asserted SHALL be discarded; no rvalid follows reset.

Configuration
REQ-017 Macro ARB_STARVE_EN SHALL control starvation avoidance.
- Defined: starvation avoidance per REQ-004 and REQ-011.
- Undefined: strict dm priority, starve_cnt absent, STARVE_LIMIT ignored.

Structure
REQ-018 Shared package SHALL hold:
- the response-state encoding (IDLE=2'd0, RESP_IF=2'd1, RESP_DM=2'd2);
- the default STARVE_LIMIT constant;
- the SRAM data width (32).
REQ-019 Starvation counter SHALL be the sub-module arb_starve_cnt (inputs clk, rst, req, gnt; output at_limit), instantiated only under ARB_STARVE_EN.

Verification
REQ-020 Cycle 1: if_req=1, if_addr=0x1000, dm_req=0.
- Cycle 1: if_gnt=1, sram_addr=0x1000.
- Cycle 2: if_rvalid=1, if_rdata equals sram_rdata=0xDEADBEEF.
REQ-021 Cycle 1: both requests; dm read at 0x2004.
- Cycle 1: dm_gnt=1, if_gnt=0, stall_req=1.
- Cycle 2: dm_rvalid=1, if_rvalid=0.
REQ-022 dm write, dm_we=4'b0011, dm_wdata=0x0000ABCD, addr 0x3000.
- Same cycle: sram_we=4'b0011, sram_wdata=0x0000ABCD.
- Next cycle: no rvalid.
REQ-023 With ARB_STARVE_EN and STARVE_LIMIT=4, both requests held for 6 cycles.
- Cycles 1-4: dm granted.
- Cycle 5: if granted.
- Cycle 6: dm granted, starve_cnt=0.
REQ-024 dm read granted, rst=1 in the next cycle.
- dm_rvalid=0 in all cycles from the reset edge on.
- State IDLE after reset.
REQ-025 Alternating if/dm reads on consecutive cycles: each rvalid appears exactly one cycle after its grant with the correct owner.
